// File: rtl/addsub_serial_param.sv
// Digit-serial adder/subtractor: DIGIT bits per clock from the LSB, carry held between cycles.
// Optional macro ADDSUB_SAT_EN: saturate s on unsigned overflow/borrow (flags stay raw).

module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
  // carry into the slice MSB recovered from the MSB half-sum
  assign o_cmsb = i_a[DIGIT-1] ^ i_b[DIGIT-1] ^ o_sum[DIGIT-1];
endmodule

module addsub_serial_param #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "addsub_serial_param: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_da, w_db, w_dsum;
  logic             w_dcout, w_dcmsb, w_last;
  logic [WIDTH-1:0] w_s_upd, w_s_fin;

  assign w_last = (r_cnt == CW'(NDIG - 1));
  assign w_da   = r_a[r_cnt*DIGIT +: DIGIT];
  assign w_db   = r_b[r_cnt*DIGIT +: DIGIT];

  addsub_digit #(.DIGIT(DIGIT)) u_dig (
    .i_a   (w_da),
    .i_b   (w_db),
    .i_cin (r_carry),
    .o_sum (w_dsum),
    .o_cout(w_dcout),
    .o_cmsb(w_dcmsb)
  );

  always_comb begin
    w_s_upd = r_s;
    w_s_upd[r_cnt*DIGIT +: DIGIT] = w_dsum;
  end

`ifdef ADDSUB_SAT_EN
  logic r_sub;
  always_comb begin
    w_s_fin = w_s_upd;
    if (!r_sub && w_dcout)     w_s_fin = '1;
    else if (r_sub && !w_dcout) w_s_fin = '0;
  end
`else
  assign w_s_fin = w_s_upd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // subtraction folded in as A + ~B + 1 at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
`ifdef ADDSUB_SAT_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b ^ {WIDTH{sub}};
          r_carry <= sub;
          r_s     <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
          r_cnt   <= '0;
`ifdef ADDSUB_SAT_EN
          r_sub   <= sub;
`endif
        end
        S_RUN: begin
          r_carry <= w_dcout;
          if (w_last) begin
            r_s    <= w_s_fin;
            r_cout <= w_dcout;
            r_ovf  <= w_dcmsb ^ w_dcout;
            r_cnt  <= '0;
          end else begin
            r_s    <= w_s_upd;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule
